// File: rtl/spi_packet_tx.sv
// spi_packet_tx -- packet framer that feeds the SPI word serializer.
//
// Emits one packet per accepted start command as a sequence of 32-bit words
// on a valid/ready stream:
//   SYNC, ADDR, LEN, ID={type,id}, HEADER_CRC, DATA words..., DATA_CRC
// A packet with zero length stops after HEADER_CRC.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pkt_tx_enable       0 aborts the current packet and holds the block in IDLE
//   pkt_tx_start        start command, taken only while idle and enabled
//   pkt_tx_addr/length/id/type   header fields, latched on an accepted start
//   pkt_tx_data/_valid  upstream payload words
//   pkt_tx_data_ready   upstream word consumed (DATA state and serializer ready)
//   tx_data/_valid      word towards the serializer, held until tx_data_ready
//   tx_data_ready       serializer accepts the word
//   pkt_tx_busy         packet in progress
//   pkt_tx_done         pulse on the last word handshake of a packet
//   error               pulse after an upstream stall timeout
//
// Build option: define PKT_TX_ERR_INJECT_EN to add inject_hdr_crc_err and
// inject_data_crc_err inputs; when the latched flag is set, bit 0 of the
// corresponding CRC word is inverted on the wire (CRC state is untouched).
//
// Also contains `crc`: CRC-32 (poly 04C11DB7, init FFFFFFFF, MSB first,
// no reflection, no final xor) over one 32-bit word per enabled cycle;
// rst clears it synchronously.

module crc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        crc_en,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  // Bit-serial update, most significant data bit first.
  always_comb begin
    crc_next = crc_reg;
    for (int b = 31; b >= 0; b--) begin
      if (crc_next[31] ^ data_in[b]) begin
        crc_next = {crc_next[30:0], 1'b0} ^ POLY;
      end else begin
        crc_next = {crc_next[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= INIT;
    end else if (crc_en) begin
      crc_reg <= crc_next;
    end
  end

  assign crc_out = crc_reg;
endmodule

module spi_packet_tx #(
  parameter logic [31:0] SYNC_WORD   = 32'h55AA55AA,
  parameter int          WORD_SIZE   = 4,
  parameter logic [15:0] STALL_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_tx_enable,
  input  logic        pkt_tx_start,
  input  logic [31:0] pkt_tx_addr,
  input  logic [31:0] pkt_tx_length,
  input  logic [15:0] pkt_tx_id,
  input  logic [15:0] pkt_tx_type,
`ifdef PKT_TX_ERR_INJECT_EN
  input  logic        inject_hdr_crc_err,
  input  logic        inject_data_crc_err,
`endif
  input  logic [31:0] pkt_tx_data,
  input  logic        pkt_tx_data_valid,
  output logic        pkt_tx_data_ready,
  output logic [31:0] tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        pkt_tx_busy,
  output logic        pkt_tx_done,
  output logic        error
);
  typedef enum logic [2:0] {
    IDLE, SYNC, ADDR, LEN, ID, HDR_CRC, DATA, DATA_CRC
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] len_reg;
  logic [31:0] id_word_reg;
  logic [31:0] words_reg;      // payload words still to send
  logic [15:0] stall_cnt_reg;
  logic        error_reg;

  logic        start_accept;
  logic        stall_timeout;
  logic        hdr_crc_en, data_crc_en;
  logic        hdr_crc_clr, data_crc_clr;
  logic [31:0] hdr_crc_out, data_crc_out;
  logic        inj_hdr, inj_data;

  // 33-bit so a length of FFFFFFFF rounds up to 2^30 words without wrapping.
  logic [32:0] words_calc;
  assign words_calc = ({1'b0, pkt_tx_length} + 33'(WORD_SIZE - 1)) / 33'(WORD_SIZE);

  assign start_accept  = (state_reg == IDLE) && pkt_tx_start && pkt_tx_enable;
  // Fires on the stall cycle that brings the count to STALL_LIMIT-1.
  assign stall_timeout = (state_reg == DATA) && !pkt_tx_data_valid && pkt_tx_enable &&
                         (stall_cnt_reg == STALL_LIMIT - 16'd2);

`ifdef PKT_TX_ERR_INJECT_EN
  logic inj_hdr_reg, inj_data_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_hdr_reg  <= 1'b0;
      inj_data_reg <= 1'b0;
    end else if (start_accept) begin
      inj_hdr_reg  <= inject_hdr_crc_err;
      inj_data_reg <= inject_data_crc_err;
    end
  end
  assign inj_hdr  = inj_hdr_reg;
  assign inj_data = inj_data_reg;
`else
  assign inj_hdr  = 1'b0;
  assign inj_data = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      id_word_reg   <= '0;
      words_reg     <= '0;
      stall_cnt_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      error_reg <= stall_timeout;
      if (start_accept) begin
        addr_reg    <= pkt_tx_addr;
        len_reg     <= pkt_tx_length;
        id_word_reg <= {pkt_tx_type, pkt_tx_id};
        words_reg   <= words_calc[31:0];
      end else if (data_crc_en) begin
        words_reg <= words_reg - 32'd1;
      end
      // Only upstream starvation counts; serializer backpressure keeps valid high.
      if (state_reg == DATA && !pkt_tx_data_valid) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end else begin
        stall_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    tx_data       = '0;
    tx_data_valid = 1'b0;
    hdr_crc_en    = 1'b0;
    data_crc_en   = 1'b0;
    pkt_tx_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pkt_tx_start && pkt_tx_enable) state_next = SYNC;
      end
      SYNC: begin
        tx_data       = SYNC_WORD;
        tx_data_valid = 1'b1;
        if (tx_data_ready) state_next = ADDR;
      end
      ADDR: begin
        tx_data       = addr_reg;
        tx_data_valid = 1'b1;
        if (tx_data_ready) begin
          hdr_crc_en = 1'b1;
          state_next = LEN;
        end
      end
      LEN: begin
        tx_data       = len_reg;
        tx_data_valid = 1'b1;
        if (tx_data_ready) begin
          hdr_crc_en = 1'b1;
          state_next = ID;
        end
      end
      ID: begin
        tx_data       = id_word_reg;
        tx_data_valid = 1'b1;
        if (tx_data_ready) begin
          hdr_crc_en = 1'b1;
          state_next = HDR_CRC;
        end
      end
      HDR_CRC: begin
        tx_data       = hdr_crc_out ^ {31'd0, inj_hdr};
        tx_data_valid = 1'b1;
        if (tx_data_ready) begin
          if (len_reg == '0) begin
            state_next  = IDLE;
            pkt_tx_done = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        // Zero-latency passthrough of the upstream stream.
        tx_data       = pkt_tx_data;
        tx_data_valid = pkt_tx_data_valid;
        if (pkt_tx_data_valid && tx_data_ready) begin
          data_crc_en = 1'b1;
          if (words_reg == 32'd1) state_next = DATA_CRC;
        end else if (stall_timeout) begin
          state_next = IDLE;
        end
      end
      DATA_CRC: begin
        tx_data       = data_crc_out ^ {31'd0, inj_data};
        tx_data_valid = 1'b1;
        if (tx_data_ready) begin
          state_next  = IDLE;
          pkt_tx_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Disable wins over everything, and suppresses the done pulse.
    if (!pkt_tx_enable) begin
      state_next  = IDLE;
      pkt_tx_done = 1'b0;
    end
  end

  assign hdr_crc_clr  = rst || (state_reg == IDLE);
  assign data_crc_clr = rst || (state_reg == IDLE) || (state_reg == HDR_CRC);

  crc u_hdr_crc (
    .clk     (clk),
    .rst     (hdr_crc_clr),
    .data_in (tx_data),
    .crc_en  (hdr_crc_en),
    .crc_out (hdr_crc_out)
  );

  crc u_data_crc (
    .clk     (clk),
    .rst     (data_crc_clr),
    .data_in (tx_data),
    .crc_en  (data_crc_en),
    .crc_out (data_crc_out)
  );

  assign pkt_tx_data_ready = (state_reg == DATA) && tx_data_ready;
  assign pkt_tx_busy       = (state_reg != IDLE);
  assign error             = error_reg;
endmodule

// File: tb/tb_spi_packet_tx.sv
module tb_spi_packet_tx;
  localparam logic [31:0] SYNC_W = 32'h55AA55AA;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_tx_enable, pkt_tx_start;
  logic [31:0] pkt_tx_addr, pkt_tx_length;
  logic [15:0] pkt_tx_id, pkt_tx_type;
  logic        inject_hdr_crc_err, inject_data_crc_err;
  logic [31:0] pkt_tx_data;
  logic        pkt_tx_data_valid, pkt_tx_data_ready;
  logic [31:0] tx_data;
  logic        tx_data_valid, tx_data_ready;
  logic        pkt_tx_busy, pkt_tx_done, pkt_tx_error;

  always #5 clk = ~clk;

  spi_packet_tx dut (
    .clk                (clk),
    .rst                (rst),
    .pkt_tx_enable      (pkt_tx_enable),
    .pkt_tx_start       (pkt_tx_start),
    .pkt_tx_addr        (pkt_tx_addr),
    .pkt_tx_length      (pkt_tx_length),
    .pkt_tx_id          (pkt_tx_id),
    .pkt_tx_type        (pkt_tx_type),
`ifdef PKT_TX_ERR_INJECT_EN
    .inject_hdr_crc_err (inject_hdr_crc_err),
    .inject_data_crc_err(inject_data_crc_err),
`endif
    .pkt_tx_data        (pkt_tx_data),
    .pkt_tx_data_valid  (pkt_tx_data_valid),
    .pkt_tx_data_ready  (pkt_tx_data_ready),
    .tx_data            (tx_data),
    .tx_data_valid      (tx_data_valid),
    .tx_data_ready      (tx_data_ready),
    .pkt_tx_busy        (pkt_tx_busy),
    .pkt_tx_done        (pkt_tx_done),
    .error              (pkt_tx_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    logic [15:0] id;
    logic [15:0] typ;
    bit          throttle;   // random serializer ready
    bit          poke;       // extra start while busy
    int          exp_words;  // hand-counted words on the wire
  } pkt_vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int done_cnt, done_idx, cycles;
  bit dready_seen, timed_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h required %08h", name, act, req);
    end
  endtask

  // CRC-32 reference as polynomial division: ((crc ^ word) * x^32) mod P.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] r;
    logic [63:0] p;
    r = {c ^ d, 32'h0};
    for (int i = 63; i >= 32; i--) begin
      p = {31'h0, 33'h104C11DB7} << (i - 32);
      if (r[i]) r = r ^ p;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] src_word(input int k);
    return 32'hC0DE0000 + 32'(k) * 32'h00010001;
  endfunction

  task automatic build_exp(input pkt_vec_t v);
    logic [31:0] c;
    logic [32:0] n;
    exp_q.delete();
    exp_q.push_back(SYNC_W);
    exp_q.push_back(v.addr);
    exp_q.push_back(v.len);
    exp_q.push_back({v.typ, v.id});
    c = 32'hFFFFFFFF;
    c = crc_model(c, v.addr);
    c = crc_model(c, v.len);
    c = crc_model(c, {v.typ, v.id});
    exp_q.push_back(c);
    if (v.len != 0) begin
      n = ({1'b0, v.len} + 33'd3) >> 2;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < int'(n); k++) begin
        exp_q.push_back(src_word(k));
        c = crc_model(c, src_word(k));
      end
      exp_q.push_back(c);
    end
  endtask

  // Runs one packet; header inputs are scrambled right after the start is taken.
  task automatic send_packet(input pkt_vec_t v);
    int data_idx;
    bit stalled;
    logic [31:0] held;
    got_q.delete();
    done_cnt = 0; done_idx = -1; cycles = 0; dready_seen = 0; timed_out = 1;
    stalled = 0; held = '0; data_idx = 0;
    @(posedge clk); #1;
    pkt_tx_start = 1; pkt_tx_addr = v.addr; pkt_tx_length = v.len;
    pkt_tx_id = v.id; pkt_tx_type = v.typ;
    @(posedge clk); #1;
    pkt_tx_start = 0; pkt_tx_addr = ~v.addr; pkt_tx_length = ~v.len;
    pkt_tx_id = ~v.id; pkt_tx_type = ~v.typ;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pkt_tx_start      = v.poke && (cyc == 1);
      tx_data_ready     = v.throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      pkt_tx_data       = src_word(data_idx);
      pkt_tx_data_valid = 1'b1;
      @(negedge clk);
      cycles++;
      if (stalled && tx_data_valid) check("held_word", tx_data, held);
      if (pkt_tx_data_ready) dready_seen = 1;
      stalled = tx_data_valid && !tx_data_ready;
      held = tx_data;
      if (tx_data_valid && tx_data_ready) got_q.push_back(tx_data);
      if (pkt_tx_data_valid && pkt_tx_data_ready) data_idx++;
      if (pkt_tx_done) begin
        done_cnt++;
        done_idx = got_q.size() - 1;
      end
      @(posedge clk); #1;
      if (!pkt_tx_busy) begin
        timed_out = 0;
        break;
      end
    end
    pkt_tx_start = 0;
    tx_data_ready = 1'b1;
    if (timed_out) check("pkt_timeout", 32'd1, 32'd0);
  endtask

  pkt_vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt, stall_cycles;
    bit err_seen;

    vecs[0] = '{32'h00001000, 32'd8,  16'h0003, 16'h0001, 1'b0, 1'b0, 8};
    vecs[1] = '{32'h00002000, 32'd0,  16'h0010, 16'h0002, 1'b0, 1'b0, 5};
    vecs[2] = '{32'h00003000, 32'd5,  16'h0020, 16'h0003, 1'b0, 1'b1, 8};
    vecs[3] = '{32'h00001000, 32'd8,  16'h0003, 16'h0001, 1'b1, 1'b0, 8};
    vecs[4] = '{32'hDEADBEEF, 32'd13, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1, 10};
    vecs[5] = '{32'h00000004, 32'd1,  16'hFFFF, 16'h8000, 1'b0, 1'b0, 7};

    rst = 1; pkt_tx_enable = 1; pkt_tx_start = 1; tx_data_ready = 1;
    pkt_tx_addr = 32'h1; pkt_tx_length = 32'd4; pkt_tx_id = 16'h1; pkt_tx_type = 16'h1;
    pkt_tx_data = 32'h12345678; pkt_tx_data_valid = 1;
    inject_hdr_crc_err = 0; inject_data_crc_err = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data",  tx_data, 32'h0);
    check("rst_valid",    32'(tx_data_valid), 32'd0);
    check("rst_dready",   32'(pkt_tx_data_ready), 32'd0);
    check("rst_busy",     32'(pkt_tx_busy), 32'd0);
    check("rst_done",     32'(pkt_tx_done), 32'd0);
    check("rst_error",    32'(pkt_tx_error), 32'd0);
    pkt_tx_start = 0;
    @(posedge clk); #1;
    rst = 0;

    // Start with enable low is ignored
    @(posedge clk); #1;
    pkt_tx_start = 1; pkt_tx_enable = 0;
    @(posedge clk); #1;
    pkt_tx_start = 0; pkt_tx_enable = 1;
    @(negedge clk);
    check("start_dis_busy",  32'(pkt_tx_busy), 32'd0);
    check("start_dis_valid", 32'(tx_data_valid), 32'd0);

    // Enable dropped while the LEN word is on the wire
    @(posedge clk); #1;
    pkt_tx_start = 1; pkt_tx_addr = 32'h2000; pkt_tx_length = 32'd8;
    pkt_tx_id = 16'h5; pkt_tx_type = 16'h6;
    @(posedge clk); #1;  // SYNC
    pkt_tx_start = 0;
    @(posedge clk); #1;  // ADDR
    @(posedge clk); #1;  // LEN
    pkt_tx_enable = 0;
    @(negedge clk);
    check("abort_len_word", tx_data, 32'd8);
    check("abort_done0",    32'(pkt_tx_done), 32'd0);
    check("abort_err0",     32'(pkt_tx_error), 32'd0);
    @(posedge clk); #1;
    check("abort_busy",     32'(pkt_tx_busy), 32'd0);
    check("abort_valid",    32'(tx_data_valid), 32'd0);
    check("abort_tx_data",  tx_data, 32'h0);
    check("abort_done1",    32'(pkt_tx_done), 32'd0);
    check("abort_err1",     32'(pkt_tx_error), 32'd0);
    pkt_tx_enable = 1;

    // Table of packets
    for (int t = 0; t < 6; t++) begin
      send_packet(vecs[t]);
      build_exp(vecs[t]);
      check($sformatf("v%0d_nwords", t), 32'(got_q.size()), 32'(vecs[t].exp_words));
      for (int w = 0; w < exp_q.size() && w < got_q.size(); w++)
        check($sformatf("v%0d_word%0d", t, w), got_q[w], exp_q[w]);
      check($sformatf("v%0d_done_cnt", t), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d_done_idx", t), 32'(done_idx), 32'(vecs[t].exp_words - 1));
      if (!vecs[t].throttle)
        check($sformatf("v%0d_cycles", t), 32'(cycles), 32'(vecs[t].exp_words));
      if (vecs[t].len == 0)
        check($sformatf("v%0d_dready_seen", t), 32'(dready_seen), 32'd0);
      $display("packet %0d: addr=%08h len=%0d words=%0d cycles=%0d", t,
               vecs[t].addr, vecs[t].len, got_q.size(), cycles);
    end

`ifdef PKT_TX_ERR_INJECT_EN
    inject_hdr_crc_err = 1;
    @(posedge clk); #1;
    inject_hdr_crc_err = 1;
    send_packet(vecs[0]);
    inject_hdr_crc_err = 0;
    build_exp(vecs[0]);
    if (got_q.size() > 4) check("inj_hdr_crc", got_q[4], exp_q[4] ^ 32'h1);
    if (got_q.size() > 7) check("inj_data_crc", got_q[7], exp_q[7]);
`endif

    // Upstream starvation in DATA -> stall timeout
    @(posedge clk); #1;
    pkt_tx_start = 1; pkt_tx_addr = 32'h3000; pkt_tx_length = 32'd8;
    pkt_tx_id = 16'h7; pkt_tx_type = 16'h8;
    pkt_tx_data_valid = 0; tx_data_ready = 1;
    @(posedge clk); #1;
    pkt_tx_start = 0;
    hs_cnt = 0; stall_cycles = 0; err_seen = 0;
    for (int cyc = 0; cyc < 70000; cyc++) begin
      @(negedge clk);
      if (pkt_tx_error) begin
        err_seen = 1;
        break;
      end
      if (tx_data_valid && tx_data_ready) hs_cnt++;
      else if (pkt_tx_busy && hs_cnt == 5) stall_cycles++;
    end
    check("stall_err_seen", 32'(err_seen), 32'd1);
    check("stall_busy",     32'(pkt_tx_busy), 32'd0);
    check("stall_hdr_words", 32'(hs_cnt), 32'd5);
    check("stall_cycles",   32'(stall_cycles), 32'd65534);
    $display("stall: error after %0d starved cycles", stall_cycles);
    @(posedge clk); #1;
    check("stall_err_pulse", 32'(pkt_tx_error), 32'd0);
    check("stall_no_trail",  32'(tx_data_valid), 32'd0);
    @(posedge clk); #1;
    pkt_tx_start = 1;
    @(posedge clk); #1;
    pkt_tx_start = 0;
    check("restart_sync",  tx_data, SYNC_W);
    check("restart_valid", 32'(tx_data_valid), 32'd1);
    check("restart_busy",  32'(pkt_tx_busy), 32'd1);
    pkt_tx_enable = 0;
    @(posedge clk); #1;
    pkt_tx_enable = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
